// File: rtl/uart_pkg.sv
// Shared UART definitions: TX/RX state encodings, parity selection and the
// supported oversampling ratios.
package uart_pkg;

    localparam int PRESCALE_W = 6;

    localparam logic [PRESCALE_W-1:0] PRESCALE_X8  = 6'd8;
    localparam logic [PRESCALE_W-1:0] PRESCALE_X16 = 6'd16;
    localparam logic [PRESCALE_W-1:0] PRESCALE_X32 = 6'd32;

    typedef enum logic [4:0] {
        TX_IDLE   = 5'b00001,
        TX_START  = 5'b00010,
        TX_DATA   = 5'b00100,
        TX_PARITY = 5'b01000,
        TX_STOP   = 5'b10000
    } tx_state_e;

    typedef enum logic [4:0] {
        RX_IDLE   = 5'b00001,
        RX_START  = 5'b00010,
        RX_DATA   = 5'b00100,
        RX_PARITY = 5'b01000,
        RX_STOP   = 5'b10000
    } rx_state_e;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } par_type_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic prescale_legal(input logic [PRESCALE_W-1:0] p);
        return (p == PRESCALE_X8) || (p == PRESCALE_X16) || (p == PRESCALE_X32);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART link: serial line and frame configuration in, parallel
// word and per-frame status strobes out.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [PRESCALE_W-1:0] PRESCALE;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;

    modport master (
        input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

    modport slave (
        output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );
endinterface

// File: rtl/uart_rx_data_sampling.sv
// Three-point majority voter around the middle of each bit period; the voted
// bit is registered and stable from edge P/2+2 onwards.
module uart_rx_data_sampling
    import uart_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  rx_s,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sampled_bit
);
    logic [PRESCALE_W-1:0] half;
    logic                  early_0;
    logic                  early_1;

    assign half = prescale >> 1;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            early_0     <= 1'b0;
            early_1     <= 1'b0;
            sampled_bit <= 1'b0;
        end else begin
            if (edge_cnt == half - 6'd1) early_0 <= rx_s;
            if (edge_cnt == half)        early_1 <= rx_s;
            if (edge_cnt == half + 6'd1) sampled_bit <= majority3(early_0, early_1, rx_s);
        end
    end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizes the serial line, walks start/data/parity/stop
// with a one-hot FSM and reports each frame as a word or an error strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic      CLK,
    input  logic      RST,
    uart_rx_if.master rx_if
);
    localparam int              BIT_W    = $clog2(DATA_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    logic                  rx_meta, rx_s;
    rx_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] edge_cnt, prescale_q;
    logic                  par_en_q;
    par_type_e             par_typ_q;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_q, p_data_q;
    logic                  par_flag, data_valid_q, par_err_q, stp_err_q;
    logic                  sampled_bit, edge_last, exp_parity;
    logic                  start_det, shift_en, parity_chk, frame_done;

    // Synchronizer resets high so releasing RST never looks like a start bit.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_if.RX_IN;
            rx_s    <= rx_meta;
        end
    end

    uart_rx_data_sampling u_sampling (
        .CLK         (CLK),
        .RST         (RST),
        .rx_s        (rx_s),
        .edge_cnt    (edge_cnt),
        .prescale    (prescale_q),
        .sampled_bit (sampled_bit)
    );

    assign edge_last  = (edge_cnt == prescale_q - 6'd1);
    assign exp_parity = (par_typ_q == ODD) ? ~^shift_q : ^shift_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= RX_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: defaults first, so no path through the case leaves a latch.
    always_comb begin
        state_d    = state_q;
        start_det  = 1'b0;
        shift_en   = 1'b0;
        parity_chk = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            RX_IDLE: if (!rx_s) begin
                start_det = 1'b1;
                state_d   = RX_START;
            end
            RX_START: if (edge_last) state_d = sampled_bit ? RX_IDLE : RX_DATA;
            RX_DATA: if (edge_last) begin
                shift_en = 1'b1;
                if (bit_cnt == LAST_BIT) state_d = par_en_q ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: if (edge_last) begin
                parity_chk = 1'b1;
                state_d    = RX_STOP;
            end
            RX_STOP: if (edge_last) begin
                frame_done = 1'b1;
                state_d    = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Configuration is frozen for the frame; unsupported ratios fall back to 8.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= EVEN;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            shift_q    <= '0;
        end else begin
            if (start_det) begin
                prescale_q <= prescale_legal(rx_if.PRESCALE) ? rx_if.PRESCALE : PRESCALE_X8;
                par_en_q   <= rx_if.PAR_EN;
                par_typ_q  <= par_type_e'(rx_if.PAR_TYP);
            end
            if (state_q == RX_IDLE) edge_cnt <= start_det ? 6'd1 : 6'd0;
            else                    edge_cnt <= edge_last ? 6'd0 : edge_cnt + 6'd1;
            if (shift_en) begin
                shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_flag     <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            if (start_det)                                par_flag <= 1'b0;
            else if (parity_chk && sampled_bit != exp_parity) par_flag <= 1'b1;
            if (frame_done) begin
                par_err_q <= par_flag;
                stp_err_q <= ~sampled_bit;
                if (!par_flag && sampled_bit) begin
                    p_data_q     <= shift_q;
                    data_valid_q <= 1'b1;
                end
            end
        end
    end

    assign rx_if.P_DATA     = p_data_q;
    assign rx_if.DATA_VALID = data_valid_q;
    assign rx_if.PAR_ERR    = par_err_q;
    assign rx_if.STP_ERR    = stp_err_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit on RX_IN and the
// strobes are logged with their cycle numbers for comparison.
module tb_uart_rx;
    import uart_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   dv_cyc[$];
    int   dv_data[$];
    int   pe_cyc[$];
    int   se_cyc[$];
    int   t0, t0b;

    uart_rx_if #(.DATA_WIDTH(8)) rx_if ();

    uart_rx #(.DATA_WIDTH(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .rx_if (rx_if)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (rx_if.DATA_VALID) begin
            dv_cyc.push_back(cyc);
            dv_data.push_back(int'(rx_if.P_DATA));
        end
        if (rx_if.PAR_ERR) pe_cyc.push_back(cyc);
        if (rx_if.STP_ERR) se_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_log();
        dv_cyc.delete();
        dv_data.delete();
        pe_cyc.delete();
        se_cyc.delete();
    endtask

    task automatic drive_bit(input logic b, input int p);
        rx_if.RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    // Called on a falling edge; t0 is the cycle in which rx_s first shows the start bit.
    task automatic send_frame(input logic [7:0] data, input logic par_bit, input logic stop_bit,
                              output int t_start);
        int p;
        p = int'(rx_if.PRESCALE);
        t_start = cyc + 2;
        drive_bit(1'b0, p);
        for (int i = 0; i < 8; i++) drive_bit(data[i], p);
        if (rx_if.PAR_EN) drive_bit(par_bit, p);
        drive_bit(stop_bit, p);
        rx_if.RX_IN = 1'b1;
    endtask

    initial begin
        rx_if.RX_IN    = 1'b1;
        rx_if.PRESCALE = 6'd8;
        rx_if.PAR_EN   = 1'b0;
        rx_if.PAR_TYP  = 1'b0;
        RST            = 1'b0;
        repeat (3) @(negedge CLK);

        check("rst_p_data", 32'(rx_if.P_DATA), 32'h0);
        check("rst_data_valid", 32'(rx_if.DATA_VALID), 32'h0);
        check("rst_par_err", 32'(rx_if.PAR_ERR), 32'h0);
        check("rst_stp_err", 32'(rx_if.STP_ERR), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(RX_IDLE));
        RST = 1'b1;
        repeat (4) @(negedge CLK);

        // P=8, no parity, 0xA5
        clear_log();
        send_frame(8'hA5, 1'b0, 1'b1, t0);
        repeat (4) @(negedge CLK);
        check("a5_dv_count", dv_cyc.size(), 1);
        check("a5_dv_cycle", q_at(dv_cyc, 0), t0 + 80);
        check("a5_data", q_at(dv_data, 0), 32'hA5);
        check("a5_pe_count", pe_cyc.size(), 0);
        check("a5_se_count", se_cyc.size(), 0);

        // P=16, even parity, 0x3C with correct parity 0
        rx_if.PRESCALE = 6'd16;
        rx_if.PAR_EN   = 1'b1;
        rx_if.PAR_TYP  = 1'b0;
        clear_log();
        send_frame(8'h3C, 1'b0, 1'b1, t0);
        repeat (4) @(negedge CLK);
        check("3c_dv_count", dv_cyc.size(), 1);
        check("3c_dv_cycle", q_at(dv_cyc, 0), t0 + 176);
        check("3c_data", q_at(dv_data, 0), 32'h3C);
        check("3c_pe_count", pe_cyc.size(), 0);

        // Same frame with wrong parity 1
        clear_log();
        send_frame(8'h3C, 1'b1, 1'b1, t0);
        repeat (4) @(negedge CLK);
        check("3c_bad_pe_count", pe_cyc.size(), 1);
        check("3c_bad_pe_cycle", q_at(pe_cyc, 0), t0 + 176);
        check("3c_bad_dv_count", dv_cyc.size(), 0);
        check("3c_bad_se_count", se_cyc.size(), 0);
        check("3c_bad_p_data_held", 32'(rx_if.P_DATA), 32'h3C);

        // P=32, no parity, 0x5A with stop bit 0
        rx_if.PRESCALE = 6'd32;
        rx_if.PAR_EN   = 1'b0;
        clear_log();
        send_frame(8'h5A, 1'b0, 1'b0, t0);
        repeat (4) @(negedge CLK);
        check("5a_se_count", se_cyc.size(), 1);
        check("5a_se_cycle", q_at(se_cyc, 0), t0 + 320);
        check("5a_dv_count", dv_cyc.size(), 0);
        check("5a_pe_count", pe_cyc.size(), 0);
        check("5a_p_data_held", 32'(rx_if.P_DATA), 32'h3C);

        // P=8 glitch: 3 low cycles, then a real 0x81 frame
        rx_if.PRESCALE = 6'd8;
        clear_log();
        rx_if.RX_IN = 1'b0;
        t0 = cyc + 2;
        repeat (3) @(negedge CLK);
        rx_if.RX_IN = 1'b1;
        repeat (6) @(negedge CLK);
        check("glitch_state_t7", 32'(dut.state_q), 32'(RX_START));
        @(negedge CLK);
        check("glitch_state_t8", 32'(dut.state_q), 32'(RX_IDLE));
        repeat (4) @(negedge CLK);
        check("glitch_strobes", dv_cyc.size() + pe_cyc.size() + se_cyc.size(), 0);
        send_frame(8'h81, 1'b0, 1'b1, t0);
        repeat (4) @(negedge CLK);
        check("81_dv_count", dv_cyc.size(), 1);
        check("81_dv_cycle", q_at(dv_cyc, 0), t0 + 80);
        check("81_data", q_at(dv_data, 0), 32'h81);

        // Back-to-back 0x00 and 0xFF with no idle gap
        clear_log();
        send_frame(8'h00, 1'b0, 1'b1, t0);
        send_frame(8'hFF, 1'b0, 1'b1, t0b);
        repeat (4) @(negedge CLK);
        check("b2b_dv_count", dv_cyc.size(), 2);
        check("b2b_first_cycle", q_at(dv_cyc, 0), t0 + 80);
        check("b2b_spacing", q_at(dv_cyc, 1) - q_at(dv_cyc, 0), 80);
        check("b2b_data0", q_at(dv_data, 0), 32'h00);
        check("b2b_data1", q_at(dv_data, 1), 32'hFF);

        // Reset in the middle of data bit 4
        clear_log();
        drive_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
        rx_if.RX_IN = 1'b0;
        repeat (4) @(negedge CLK);
        check("mid_state_data", 32'(dut.state_q), 32'(RX_DATA));
        RST = 1'b0;
        #1;
        check("mid_rst_p_data", 32'(rx_if.P_DATA), 32'h0);
        check("mid_rst_data_valid", 32'(rx_if.DATA_VALID), 32'h0);
        check("mid_rst_errs", 32'({rx_if.PAR_ERR, rx_if.STP_ERR}), 32'h0);
        check("mid_rst_state", 32'(dut.state_q), 32'(RX_IDLE));
        rx_if.RX_IN = 1'b1;
        @(negedge CLK);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        check("mid_rst_no_strobe", dv_cyc.size() + pe_cyc.size() + se_cyc.size(), 0);
        send_frame(8'h33, 1'b0, 1'b1, t0);
        repeat (4) @(negedge CLK);
        check("33_dv_count", dv_cyc.size(), 1);
        check("33_dv_cycle", q_at(dv_cyc, 0), t0 + 80);
        check("33_data", q_at(dv_data, 0), 32'h33);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the multi-clock system's UART link. It runs in the oversampled RX clock domain and recovers 8-bit frames from the serial line: start bit, 8 data bits LSB first, optional parity bit, and one stop bit. Each frame is checked for parity and stop errors, and a good frame is presented as a parallel word with a one-cycle valid strobe to the downstream synchronizer and system controller.

## Interface
- DATA_WIDTH, 8, data bits per frame.
- CLK  in  1  oversampling clock, at PRESCALE × baud.
- RST  in  1  asynchronous, active-low reset.
- RX_IN  in  1  serial line; idles high; asynchronous to CLK.
- PRESCALE  in  6  oversampling ratio; legal values are 8, 16 and 32, and any other value gives undefined behaviour.
- PAR_EN  in  1  1 means a parity bit is present.
- PAR_TYP  in  1  0 selects even parity, 1 selects odd.
- P_DATA  out  DATA_WIDTH  last good received word.
- DATA_VALID  out  1  one-cycle strobe when P_DATA is updated.
- PAR_ERR  out  1  one-cycle strobe when a frame has a parity mismatch.
- STP_ERR  out  1  one-cycle strobe when a frame's stop bit is sampled as 0.

## Operation
- RX_IN passes through a 2-flop synchronizer; all behaviour below refers to the synchronized signal rx_s.
- Counters:
  - edge_cnt counts 0..PRESCALE-1 within a bit period.
  - bit_cnt counts 0..DATA_WIDTH-1 in the DATA state.
- Bit sampling: take a majority vote of rx_s at edges P/2-1, P/2 and P/2+1, where P = PRESCALE. The voted bit is registered and stable from edge P/2+2.
- PRESCALE, PAR_EN and PAR_TYP are latched when a start bit is detected. Changes to them mid-frame are ignored.
- State machine, one-hot, with states IDLE, START, DATA, PARITY and STOP:
  - IDLE: edge_cnt = 0. When rx_s = 0, that cycle is T0, edge 0 of the start bit, and the next state is START.
  - START: at edge P-1, a voted bit of 1 is a glitch and the next state is IDLE with no outputs. A voted bit of 0 moves to DATA.
  - DATA: the voted bit is shifted in LSB first at edge P-1 of each bit. After bit_cnt = 7, the next state is PARITY if PAR_EN = 1, otherwise STOP.
  - PARITY: at edge P-1, compare the voted bit with the parity computed over the shift register. Expected parity is XOR of the data bits for even, XNOR for odd. A mismatch sets an internal parity-error flag. Next state is STOP.
  - STOP: at edge P-1, a voted bit of 0 sets an internal stop-error flag. Next state is IDLE.
- Frame completion, evaluated at edge P-1 of the stop bit:
  - No errors: P_DATA is loaded from the shift register and DATA_VALID pulses.
  - Any error: PAR_ERR and/or STP_ERR pulse, DATA_VALID stays 0, and P_DATA holds its previous value.
- Reset values: every output is 0, the state is IDLE, and all counters and flags are 0. Asserting RST mid-frame aborts the frame with no strobe. The first falling edge after RST is released starts a new frame.

## Timing
- Frame length N = 10 bits without parity, 11 with parity.
- DATA_VALID, PAR_ERR and STP_ERR are registered. They assert in cycle T0 + N·P for exactly one cycle.
- Input latency of 2 cycles from RX_IN to rx_s is not counted in T0.
- Back-to-back frames:
  - The FSM is in IDLE in cycle T0 + N·P.
  - If rx_s = 0 in that cycle, it is T0 of the next frame, even while the strobe is high.
  - Consecutive DATA_VALID strobes are therefore exactly N·P cycles apart.
- A glitched start returns to IDLE at T0 + P. Start detection is possible again from T0 + P.
- Outputs change only on the CLK rising edge. RST acts immediately.

## Structure
- Shared package uart_pkg holds:
  - the RX state encodings (5-bit one-hot) alongside the existing TX encodings,
  - parity type constants (EVEN = 0, ODD = 1),
  - the legal PRESCALE values.
- The natural sub-module is uart_rx_data_sampling, the 3-point majority voter driven by edge_cnt and the latched PRESCALE.
- The FSM, counters, deserializer and parity/stop checking live in uart_rx.

## Test plan
- PRESCALE = 8, PAR_EN = 0, frame 0xA5: DATA_VALID = 1 at T0+80 only, P_DATA = 0xA5, both error strobes stay 0.
- PRESCALE = 16, PAR_EN = 1, PAR_TYP = 0, frame 0x3C with parity 0: valid at T0+176 with P_DATA = 0x3C. Same frame with parity 1: PAR_ERR pulses at T0+176, DATA_VALID stays 0, P_DATA stays 0x3C.
- PRESCALE = 32, PAR_EN = 0, frame 0x5A with stop bit 0: STP_ERR pulses at T0+320, no DATA_VALID.
- PRESCALE = 8, RX_IN low for 3 cycles then high: FSM is in IDLE at T0+8 with no strobes. A following 0x81 frame is received correctly.
- PRESCALE = 8, frames 0x00 and 0xFF back to back with no idle gap: two DATA_VALID pulses 80 cycles apart, with P_DATA = 0x00 then 0xFF.
- RST pulsed during DATA bit 4: all outputs are 0 immediately. The next frame 0x33 gives DATA_VALID with P_DATA = 0x33.
